// File: rtl/trace_pkg.sv
// Shared types and width helpers for the cycle trace unit.
// Holds the run-state enum and the channel-index / entry width functions.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single channel still needs a 1-bit index field.
  function automatic int ch_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  function automatic int entry_w(
    input int cw,
    input int ch,
    input int dw
  );
    return cw + ch_w(ch) + dw;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO for trace entries.
// Ports: CLK, RST_N, clr_i, push_i/din_i, pop_i, dout_o, empty_o, full_o.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wp_q, wp_d;
  logic [AW:0]      rp_q, rp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);

  // A full FIFO still accepts a push when the head leaves
  // in the same cycle; a pop on empty is ignored.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (clr_i) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (do_push) wp_d = wp_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rp_d = rp_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !clr_i) mem_q[wp_q[AW-1:0]] <= din_i;
  end

  // Storage is not reset, so mask the head while empty.
  assign dout_o = empty_o ? '0 : mem_q[rp_q[AW-1:0]];

endmodule

// File: rtl/cycle_trace_unit.sv
// Run-cycle counter and change tracer for up to CH pipeline signals.
// In: CLK RST_N start clear cycle_limit ch_valid ch_data rd_en.
// Out: rd_cycle rd_ch rd_data empty full drop_cnt cycle_cnt running done.
module cycle_trace_unit
  import trace_pkg::*;
#(
  parameter int CH    = 4,
  parameter int DW    = 32,
  parameter int CW    = 32,
  parameter int DEPTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic                  clear,
  input  logic [CW-1:0]         cycle_limit,
  input  logic [CH-1:0]         ch_valid,
  input  logic [CH*DW-1:0]      ch_data,
  input  logic                  rd_en,
  output logic [CW-1:0]         rd_cycle,
  output logic [ch_w(CH)-1:0]   rd_ch,
  output logic [DW-1:0]         rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [15:0]           drop_cnt,
  output logic [CW-1:0]         cycle_cnt,
  output logic                  running,
  output logic                  done
);

  localparam int CHW = ch_w(CH);
  localparam int EW  = entry_w(CW, CH, DW);

  state_t          st_q, st_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [CH*DW-1:0] hist_q;
  logic [CH-1:0]   hvld_q;
  logic [CHW-1:0]  rr_q, rr_d;
  logic [15:0]     drop_q, drop_d;

  logic            last;
  logic [CH-1:0]   cand;
  logic            gnt_vld;
  logic [CHW-1:0]  gnt_idx;
  logic [DW-1:0]   gnt_data;
  logic [EW-1:0]   wdata;
  logic [EW-1:0]   rdata;

  assign last = (st_q == RUN) &&
                (cycle_limit != '0) &&
                (cyc_q == cycle_limit - CW'(1));

  always_comb begin
    st_d = st_q;
    if (clear) begin
      st_d = IDLE;
    end else begin
      unique case (st_q)
        IDLE:    if (start) st_d = RUN;
        RUN:     if (last)  st_d = DONE;
        DONE:    st_d = DONE;
        default: st_d = IDLE;
      endcase
    end
  end

  // The final RUN cycle keeps its count so DONE shows limit-1.
  always_comb begin
    cyc_d = cyc_q;
    if (clear) begin
      cyc_d = '0;
    end else if (st_q == IDLE && start) begin
      cyc_d = '0;
    end else if (st_q == RUN && !last) begin
      cyc_d = cyc_q + CW'(1);
    end
  end

  always_comb begin
    cand = '0;
    for (int i = 0; i < CH; i++) begin
      cand[i] = (st_q == RUN) && !clear && ch_valid[i] &&
                (!hvld_q[i] ||
                 ch_data[i*DW +: DW] != hist_q[i*DW +: DW]);
    end
  end

  // Round-robin: first candidate at or after rr_q wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_data = '0;
    for (int k = 0; k < CH; k++) begin
      if (!gnt_vld && cand[(int'(rr_q) + k) % CH]) begin
        gnt_vld  = 1'b1;
        gnt_idx  = CHW'((int'(rr_q) + k) % CH);
        gnt_data = ch_data[((int'(rr_q) + k) % CH)*DW +: DW];
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (clear) begin
      rr_d = '0;
    end else if (gnt_vld) begin
      rr_d = CHW'((int'(gnt_idx) + 1) % CH);
    end
  end

  // An entry is lost only when full and the head stays put.
  always_comb begin
    drop_d = drop_q;
    if (clear) begin
      drop_d = '0;
    end else if (gnt_vld && full && !rd_en &&
                 drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q   <= IDLE;
      cyc_q  <= '0;
      rr_q   <= '0;
      drop_q <= '0;
    end else begin
      st_q   <= st_d;
      cyc_q  <= cyc_d;
      rr_q   <= rr_d;
      drop_q <= drop_d;
    end
  end

  // History tracks the granted channel even if its entry drops.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hist_q <= '0;
      hvld_q <= '0;
    end else if (clear) begin
      hist_q <= '0;
      hvld_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (gnt_vld && gnt_idx == CHW'(i)) begin
          hist_q[i*DW +: DW] <= gnt_data;
          hvld_q[i]          <= 1'b1;
        end
      end
    end
  end

  assign wdata = {cyc_q, gnt_idx, gnt_data};

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clr_i   (clear),
    .push_i  (gnt_vld),
    .din_i   (wdata),
    .pop_i   (rd_en),
    .dout_o  (rdata),
    .empty_o (empty),
    .full_o  (full)
  );

  assign rd_cycle  = rdata[EW-1 -: CW];
  assign rd_ch     = rdata[DW +: CHW];
  assign rd_data   = rdata[DW-1:0];
  assign drop_cnt  = drop_q;
  assign cycle_cnt = cyc_q;
  assign running   = (st_q == RUN);
  assign done      = (st_q == DONE);

endmodule

// File: tb/tb_cycle_trace_unit.sv
// Directed bench for cycle_trace_unit (CH=4, DEPTH=4).
// One task per scenario, each with its own inline checks.
module tb_cycle_trace_unit;

  logic         CLK;
  logic         RST_N;
  logic         start;
  logic         clear;
  logic [31:0]  cycle_limit;
  logic [3:0]   ch_valid;
  logic [127:0] ch_data;
  logic         rd_en;
  logic [31:0]  rd_cycle;
  logic [1:0]   rd_ch;
  logic [31:0]  rd_data;
  logic         empty;
  logic         full;
  logic [15:0]  drop_cnt;
  logic [31:0]  cycle_cnt;
  logic         running;
  logic         done;
  logic [65:0]  head;

  int checks = 0;
  int errors = 0;

  cycle_trace_unit #(
    .CH    (4),
    .DW    (32),
    .CW    (32),
    .DEPTH (4)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .start       (start),
    .clear       (clear),
    .cycle_limit (cycle_limit),
    .ch_valid    (ch_valid),
    .ch_data     (ch_data),
    .rd_en       (rd_en),
    .rd_cycle    (rd_cycle),
    .rd_ch       (rd_ch),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .drop_cnt    (drop_cnt),
    .cycle_cnt   (cycle_cnt),
    .running     (running),
    .done        (done)
  );

  assign head = {rd_cycle, rd_ch, rd_data};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_clear();
    ch_valid = '0;
    ch_data  = '0;
    rd_en    = 1'b0;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_empty: got %b exp 1", empty);
    end
    checks++;
    if ({full, running, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b exp 000",
               {full, running, done});
    end
    checks++;
    if ({cycle_cnt, drop_cnt} !== 48'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %h exp 0",
               {cycle_cnt, drop_cnt});
    end
    checks++;
    if (head !== 66'd0) begin
      errors++;
      $display("FAIL reset_rd: got %h exp 0", head);
    end
  endtask

  task automatic test_limit();
    do_clear();
    cycle_limit = 32'd5;
    do_start();
    checks++;
    if ({running, cycle_cnt} !== {1'b1, 32'd0}) begin
      errors++;
      $display("FAIL lim_start: got %b/%0d exp 1/0",
               running, cycle_cnt);
    end
    tick(4);
    checks++;
    if ({running, done, cycle_cnt} !== {2'b10, 32'd4}) begin
      errors++;
      $display("FAIL lim_last: got %b%b/%0d exp 10/4",
               running, done, cycle_cnt);
    end
    tick();
    checks++;
    if ({running, done, empty} !== 3'b011) begin
      errors++;
      $display("FAIL lim_done: got %b exp 011",
               {running, done, empty});
    end
    checks++;
    if (cycle_cnt !== 32'd4) begin
      errors++;
      $display("FAIL lim_hold: got %0d exp 4", cycle_cnt);
    end
    do_start();
    tick();
    checks++;
    if ({done, cycle_cnt} !== {1'b1, 32'd4}) begin
      errors++;
      $display("FAIL lim_start_ign: got %b/%0d exp 1/4",
               done, cycle_cnt);
    end
    do_clear();
    checks++;
    if ({running, done, cycle_cnt} !== {2'b00, 32'd0}) begin
      errors++;
      $display("FAIL lim_clear: got %b%b/%0d exp 00/0",
               running, done, cycle_cnt);
    end
  endtask

  task automatic test_last_cycle();
    do_clear();
    cycle_limit = 32'd3;
    do_start();
    tick(2);
    ch_valid = 4'b0010;
    ch_data[32 +: 32] = 32'h55;
    tick();
    checks++;
    if ({done, cycle_cnt} !== {1'b1, 32'd2}) begin
      errors++;
      $display("FAIL last_done: got %b/%0d exp 1/2",
               done, cycle_cnt);
    end
    checks++;
    if (head !== {32'd2, 2'd1, 32'h55}) begin
      errors++;
      $display("FAIL last_entry: got %h exp %h",
               head, {32'd2, 2'd1, 32'h55});
    end
    do_clear();
    cycle_limit = 32'd0;
  endtask

  task automatic test_change();
    do_clear();
    do_start();
    ch_valid = 4'b0001;
    ch_data[31:0] = 32'hA;
    tick();
    checks++;
    if ({empty, head} !== {1'b0, 32'd0, 2'd0, 32'hA}) begin
      errors++;
      $display("FAIL chg_first: got %b %h exp 0 %h",
               empty, head, {32'd0, 2'd0, 32'hA});
    end
    tick(2);
    ch_data[31:0] = 32'hB;
    tick();
    pop();
    checks++;
    if (head !== {32'd3, 2'd0, 32'hB}) begin
      errors++;
      $display("FAIL chg_second: got %h exp %h",
               head, {32'd3, 2'd0, 32'hB});
    end
    pop();
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL chg_once: got empty=%b exp 1", empty);
    end
    ch_data[31:0] = 32'hC;
    pop();
    checks++;
    if ({empty, head} !== {1'b0, 32'd6, 2'd0, 32'hC}) begin
      errors++;
      $display("FAIL chg_pop_empty: got %b %h exp 0 %h",
               empty, head, {32'd6, 2'd0, 32'hC});
    end
    pop();
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL chg_drain: got empty=%b exp 1", empty);
    end
  endtask

  task automatic test_round_robin();
    do_clear();
    do_start();
    ch_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      ch_data[i*32 +: 32] = 32'h10 + 32'(i);
    end
    tick(4);
    checks++;
    if ({full, drop_cnt} !== {1'b1, 16'd0}) begin
      errors++;
      $display("FAIL rr_full: got %b/%0d exp 1/0",
               full, drop_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (head !== {32'(k), 2'(k), 32'h10 + 32'(k)}) begin
        errors++;
        $display("FAIL rr_order%0d: got %h exp %h", k, head,
                 {32'(k), 2'(k), 32'h10 + 32'(k)});
      end
      pop();
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL rr_empty: got %b exp 1", empty);
    end
    ch_data[31:0]  = 32'h20;
    ch_data[127:96] = 32'h23;
    tick(2);
    checks++;
    if (head !== {32'd8, 2'd0, 32'h20}) begin
      errors++;
      $display("FAIL rr_wrap0: got %h exp %h",
               head, {32'd8, 2'd0, 32'h20});
    end
    pop();
    checks++;
    if (head !== {32'd9, 2'd3, 32'h23}) begin
      errors++;
      $display("FAIL rr_wrap3: got %h exp %h",
               head, {32'd9, 2'd3, 32'h23});
    end
    pop();
  endtask

  task automatic test_overflow();
    logic [65:0] exp_q [4];
    exp_q[0] = {32'd1, 2'd0, 32'd2};
    exp_q[1] = {32'd2, 2'd0, 32'd3};
    exp_q[2] = {32'd3, 2'd0, 32'd4};
    exp_q[3] = {32'd6, 2'd0, 32'd7};
    do_clear();
    do_start();
    ch_valid = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      ch_data[31:0] = 32'(k + 1);
      tick();
    end
    checks++;
    if ({full, drop_cnt} !== {1'b1, 16'd2}) begin
      errors++;
      $display("FAIL ovf_drop: got %b/%0d exp 1/2",
               full, drop_cnt);
    end
    checks++;
    if (head !== {32'd0, 2'd0, 32'd1}) begin
      errors++;
      $display("FAIL ovf_head: got %h exp %h",
               head, {32'd0, 2'd0, 32'd1});
    end
    ch_data[31:0] = 32'd7;
    pop();
    checks++;
    if ({full, drop_cnt} !== {1'b1, 16'd2}) begin
      errors++;
      $display("FAIL ovf_pushpop: got %b/%0d exp 1/2",
               full, drop_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (head !== exp_q[k]) begin
        errors++;
        $display("FAIL ovf_entry%0d: got %h exp %h",
                 k, head, exp_q[k]);
      end
      pop();
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL ovf_empty: got %b exp 1", empty);
    end
  endtask

  task automatic test_clear();
    do_clear();
    checks++;
    if (drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clr_drop: got %0d exp 0", drop_cnt);
    end
    do_start();
    ch_valid = 4'b0001;
    for (int k = 1; k <= 3; k++) begin
      ch_data[31:0] = 32'(k);
      tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if ({running, empty, full, cycle_cnt} !==
        {3'b010, 32'd0}) begin
      errors++;
      $display("FAIL clr_state: got %b/%0d exp 010/0",
               {running, empty, full}, cycle_cnt);
    end
    do_start();
    tick();
    checks++;
    if ({empty, head} !== {1'b0, 32'd0, 2'd0, 32'd3}) begin
      errors++;
      $display("FAIL clr_recapture: got %b %h exp 0 %h",
               empty, head, {32'd0, 2'd0, 32'd3});
    end
  endtask

  task automatic test_async_reset();
    tick();
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({empty, full, running, done} !== 4'b1000) begin
      errors++;
      $display("FAIL arst_flags: got %b exp 1000",
               {empty, full, running, done});
    end
    checks++;
    if ({cycle_cnt, drop_cnt, head} !== 114'd0) begin
      errors++;
      $display("FAIL arst_vals: got %h exp 0",
               {cycle_cnt, drop_cnt, head});
    end
    #2;
    RST_N = 1'b1;
    tick();
    checks++;
    if ({empty, running, cycle_cnt} !== {2'b10, 32'd0}) begin
      errors++;
      $display("FAIL arst_after: got %b/%0d exp 10/0",
               {empty, running}, cycle_cnt);
    end
  endtask

  initial begin
    RST_N       = 1'b0;
    start       = 1'b0;
    clear       = 1'b0;
    cycle_limit = '0;
    ch_valid    = '0;
    ch_data     = '0;
    rd_en       = 1'b0;
    #12;
    RST_N = 1'b1;
    #1;
    test_reset();
    test_limit();
    test_last_cycle();
    test_change();
    test_round_robin();
    test_overflow();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cycle_trace_unit.md
# cycle_trace_unit

Synthesizable, parametrised replacement for the simulation-only cycle counter, `$monitor` and `$stop` harness around the MIPS pipeline. It counts run cycles and watches up to CH pipeline signals, such as EX/MEM ALU result, write-back data or PC. Each time a watched value changes, it records a {cycle, channel, value} entry in an on-chip trace FIFO, and it raises `done` after a programmable cycle limit. The block sits beside the MIPS core and is read out by a debug host or testbench.

## Interface
- CH, 4: number of watched channels (1..16)
- DW, 32: channel data width
- CW, 32: cycle counter and timestamp width
- DEPTH, 16: trace FIFO entries (power of two, ≥2)
- CLK  in  1  single clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- start  in  1  pulse: IDLE→RUN
- clear  in  1  synchronous clear of counters, FIFO, history; →IDLE
- cycle_limit  in  CW  run length in cycles; 0 = unlimited
- ch_valid  in  CH  per-channel sample qualifier
- ch_data  in  CH*DW  channel i at bits [i*DW +: DW]
- rd_en  in  1  pop head entry
- rd_cycle  out  CW  head timestamp
- rd_ch  out  max(1,$clog2(CH))  head channel index
- rd_data  out  DW  head value
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- drop_cnt  out  16  entries lost to full FIFO, saturating
- cycle_cnt  out  CW  current run cycle
- running  out  1  state == RUN
- done  out  1  state == DONE

## Operation
- States and transitions:
  - IDLE→RUN on `start`.
  - RUN→DONE in the cycle when `cycle_cnt == cycle_limit-1` and `cycle_limit != 0`.
  - DONE→IDLE only on `clear`. `start` is ignored in RUN and DONE.
  - `clear` has priority over everything and applies in any state.
- cycle_cnt: zeroed on the IDLE→RUN edge. Increments by 1 every RUN cycle and wraps modulo 2^CW. Holds its value in DONE.
- Change detection (RUN only):
  - Channel i is a candidate when `ch_valid[i]` is high and either `hist_vld[i]==0` or `ch_data[i] != hist[i]`.
  - `hist`/`hist_vld` clear on reset and on `clear`, so the first valid sample of each channel is always a candidate.
- Arbitration:
  - At most one entry is produced per cycle.
  - Round-robin search starts at pointer `rr`. After a grant to channel g, `rr = (g+1) mod CH`.
  - Only the granted channel updates `hist[g] <= ch_data[g]` and `hist_vld[g] <= 1`. Ungranted candidates stay candidates and are captured later with their then-current value.
- Push: entry {cycle_cnt, g, ch_data[g]}.
  - Allowed when `!full`, or when `full && rd_en` in the same cycle.
  - Otherwise the entry is dropped: `drop_cnt` increments, saturating at 0xFFFF, and `hist[g]` still updates.
- Read: show-ahead. `rd_*` are valid whenever `!empty`. `rd_en` pops; `rd_en` while empty is ignored.

## Timing
- Reset: state IDLE, `empty=1`, and `full`, `drop_cnt`, `cycle_cnt`, `running`, `done`, `rr` and all `rd_*` are 0.
- Capture latency: a candidate at edge N is visible on `rd_*`, with `empty=0`, after edge N. Write-to-read latency is 1 cycle.
- Simultaneous push and pop on a non-empty FIFO: occupancy is unchanged.
- Push into an empty FIFO with `rd_en` high: the pop is ignored and the entry appears next cycle.
- `done` rises one cycle after the last RUN cycle. The last RUN cycle's candidate is still captured.
- Reset asserted mid-run: immediate return to reset values, with no partial entries.

## Structure
- Shared package `trace_pkg`:
  - state enum {IDLE, RUN, DONE}
  - entry width constant CW+$clog2(CH)+DW
  - channel-index width function
- Sub-module `trace_fifo`: parametrised synchronous FIFO (DEPTH, WIDTH) with show-ahead output, full/empty and pop-on-full-push support.
- The top level holds the FSM, cycle counter, history registers and round-robin arbiter.

## Test plan
- Reset, then `start`, with `cycle_limit=5` and no valid inputs → `done` rises after 5 RUN cycles, `cycle_cnt=4` held, `empty=1`.
- CH=4: ch0 valid with constant 0xA at cycle 0 → exactly one entry {0, 0, 0xA}. Changes to 0xB at cycle 3 → entry {3, 0, 0xB}.
- All 4 channels first valid in the same cycle 0 → entries for ch 0, 1, 2, 3 at cycles 0, 1, 2, 3, in order. Next grant starts at ch0.
- DEPTH=4, with no reads and 6 distinct changes → `full=1`, 4 entries retained, `drop_cnt=2`. `full && rd_en` plus a new change → occupancy stays 4 and `drop_cnt` stays 2.
- `clear` pulsed mid-run with 3 entries stored → next cycle IDLE, `empty=1`, `cycle_cnt=0`. After `start`, an unchanged prior value is captured again.
- RST_N asserted for a fraction of a cycle during RUN → all outputs at reset values immediately, without waiting for a CLK edge.
